ghash_seq: RTL and testbench

GHASH_SEQ -- requirements
Module: ghash_seq

---
 rtl/gcm_pkg.sv | 30 +++
 rtl/ghash_seq_if.sv | 30 +++
 rtl/ghash.sv | 54 +++++
 rtl/ghash_seq.sv | 115 +++++++++++
 tb/tb_ghash_seq.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcm_pkg.sv
// Shared GCM definitions: sequencer state encoding, datapath widths and the
// partial-block byte mask.
package gcm_pkg;

    localparam int BLK_W = 128;
    localparam int LEN_W = 64;

    // GCM reduction constant in the bit-reflected field representation.
    localparam logic [BLK_W-1:0] GF_R = {8'he1, 120'h0};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BLK = 3'd1,
        ST_MUL      = 3'd2,
        ST_LEN_MUL  = 3'd3,
        ST_DONE     = 3'd4
    } gcm_state_e;

    // Keep the first nbytes bytes (byte 0 at the MSB end), zero the rest.
    function automatic logic [BLK_W-1:0] byte_mask(input logic [BLK_W-1:0] blk,
                                                   input logic [4:0]       nbytes);
        logic [BLK_W-1:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < nbytes) m[BLK_W-1-8*i -: 8] = blk[BLK_W-1-8*i -: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/ghash_seq_if.sv
// Producer/consumer bundle of the GHASH sequencer.
// Block handshake: blk_valid/blk_data/blk_type/blk_bytes are held by the master
// until a cycle where blk_valid && blk_ready; that cycle is the one transfer.
interface ghash_seq_if;
    import gcm_pkg::*;

    logic             start;
    logic [BLK_W-1:0] h_key;
    logic             blk_valid;
    logic             blk_ready;
    logic [BLK_W-1:0] blk_data;
    logic             blk_type;
    logic [4:0]       blk_bytes;
    logic             fin;
    logic             s_valid;
    logic [BLK_W-1:0] s_data;
    logic             busy;
    logic             err;

    modport master (
        output start, h_key, blk_valid, blk_data, blk_type, blk_bytes, fin,
        input  blk_ready, s_valid, s_data, busy, err
    );

    modport slave (
        input  start, h_key, blk_valid, blk_data, blk_type, blk_bytes, fin,
        output blk_ready, s_valid, s_data, busy, err
    );

endinterface

// File: rtl/ghash.sv
// Bit-serial GF(2^128) multiplier: y_out = (data ^ y_prev) * H, one bit per clock.
// Loads on start, runs 128 shift/xor steps, then pulses done with y_out valid.
module ghash
    import gcm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [BLK_W-1:0] data_i,
    input  logic [BLK_W-1:0] y_prev_i,
    input  logic [BLK_W-1:0] h_i,
    output logic             done_o,
    output logic [BLK_W-1:0] y_out_o
);

    logic [BLK_W-1:0] x_q, v_q, z_q;
    logic [7:0]       cnt_q;
    logic             run_q, done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            v_q    <= '0;
            z_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                x_q   <= data_i ^ y_prev_i;
                v_q   <= h_i;
                z_q   <= '0;
                cnt_q <= '0;
                run_q <= 1'b1;
            end else if (run_q) begin
                // The extra step after the last bit gives a fixed, data-independent latency.
                if (cnt_q == 8'd128) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    if (x_q[BLK_W-1]) z_q <= z_q ^ v_q;
                    v_q   <= v_q[0] ? ((v_q >> 1) ^ GF_R) : (v_q >> 1);
                    x_q   <= x_q << 1;
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign done_o  = done_q;
    assign y_out_o = z_q;

endmodule

// File: rtl/ghash_seq.sv
// GHASH message sequencer: pads and hashes AAD/CT blocks through one serial
// multiplier, tracks bit lengths and finishes with the length block.
module ghash_seq
    import gcm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ghash_seq_if.slave gs,
    output gcm_state_e state_o
);

    gcm_state_e       state_q;
    logic [BLK_W-1:0] h_q, y_q, mult_x_q, s_data_q;
    logic [LEN_W-1:0] len_a_q, len_c_q;
    logic             seen_ct_q, err_q, s_valid_q, mult_start_q;

    logic             mult_done;
    logic [BLK_W-1:0] mult_y;
    logic             blk_ok;
    logic [LEN_W-1:0] len_inc;

    // A block is hashable only with 1..16 bytes and no AAD once CT has started.
    assign blk_ok  = (gs.blk_bytes != 5'd0) && (gs.blk_bytes <= 5'd16) &&
                     !(!gs.blk_type && seen_ct_q);
    assign len_inc = {{(LEN_W-8){1'b0}}, gs.blk_bytes, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            h_q          <= '0;
            y_q          <= '0;
            mult_x_q     <= '0;
            s_data_q     <= '0;
            len_a_q      <= '0;
            len_c_q      <= '0;
            seen_ct_q    <= 1'b0;
            err_q        <= 1'b0;
            s_valid_q    <= 1'b0;
            mult_start_q <= 1'b0;
        end else begin
            s_valid_q    <= 1'b0;
            mult_start_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (gs.start) begin
                        h_q       <= gs.h_key;
                        y_q       <= '0;
                        len_a_q   <= '0;
                        len_c_q   <= '0;
                        seen_ct_q <= 1'b0;
                        err_q     <= 1'b0;
                        state_q   <= ST_WAIT_BLK;
                    end
                end
                ST_WAIT_BLK: begin
                    // A block offered together with fin wins; fin must be re-pulsed.
                    if (gs.blk_valid) begin
                        if (blk_ok) begin
                            mult_x_q     <= byte_mask(gs.blk_data, gs.blk_bytes);
                            mult_start_q <= 1'b1;
                            state_q      <= ST_MUL;
                            if (gs.blk_type) begin
                                len_c_q   <= len_c_q + len_inc;
                                seen_ct_q <= 1'b1;
                            end else begin
                                len_a_q   <= len_a_q + len_inc;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (gs.fin) begin
                        mult_x_q     <= {len_a_q, len_c_q};
                        mult_start_q <= 1'b1;
                        state_q      <= ST_LEN_MUL;
                    end
                end
                ST_MUL: begin
                    if (mult_done) begin
                        y_q     <= mult_y;
                        state_q <= ST_WAIT_BLK;
                    end
                end
                ST_LEN_MUL: begin
                    if (mult_done) begin
                        y_q       <= mult_y;
                        s_data_q  <= mult_y;
                        s_valid_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ghash u_ghash (
        .clk      (clk),
        .rst      (rst),
        .start_i  (mult_start_q),
        .data_i   (mult_x_q),
        .y_prev_i (y_q),
        .h_i      (h_q),
        .done_o   (mult_done),
        .y_out_o  (mult_y)
    );

    assign gs.blk_ready = (state_q == ST_WAIT_BLK);
    assign gs.s_valid   = s_valid_q;
    assign gs.s_data    = s_data_q;
    assign gs.err       = err_q;
    assign gs.busy      = (state_q == ST_WAIT_BLK) || (state_q == ST_MUL) ||
                          (state_q == ST_LEN_MUL) || s_valid_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_ghash_seq.sv
// Randomised bench for ghash_seq: reference GHASH built from polynomial
// multiplication modulo x^128+x^7+x^2+x+1, expected results queued per message.
module tb_ghash_seq;
    import gcm_pkg::*;

    logic       clk;
    logic       rst;
    gcm_state_e st;

    ghash_seq_if gs ();

    ghash_seq dut (
        .clk     (clk),
        .rst     (rst),
        .gs      (gs),
        .state_o (st)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    logic [127:0] exp_q[$];
    logic [0:0]   exp_err_q[$];

    // message model
    logic [127:0] m_h, m_y;
    logic [63:0]  m_la, m_lc;
    logic         m_ct, m_err;

    localparam logic [127:0] H_ID = 128'h8000_0000_0000_0000_0000_0000_0000_0000;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Field product with GCM bit order (bit 127 is the x^0 coefficient).
    function automatic logic [127:0] ref_mul(input logic [127:0] a, input logic [127:0] b);
        logic [254:0] pa, pb, prod, poly;
        logic [127:0] r;
        pa = '0; pb = '0; prod = '0; poly = '0; r = '0;
        for (int i = 0; i < 128; i++) begin
            pa[i] = a[127-i];
            pb[i] = b[127-i];
        end
        for (int i = 0; i < 128; i++) if (pa[i]) prod = prod ^ (pb << i);
        poly[128] = 1'b1; poly[7] = 1'b1; poly[2] = 1'b1; poly[1] = 1'b1; poly[0] = 1'b1;
        for (int k = 254; k >= 128; k--) if (prod[k]) prod = prod ^ (poly << (k - 128));
        for (int i = 0; i < 128; i++) r[127-i] = prod[i];
        return r;
    endfunction

    function automatic logic [127:0] pad(input logic [127:0] d, input int n);
        logic [127:0] ones;
        ones = '1;
        return d & ~(ones >> (8 * n));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string who);
        int k = 0;
        @(negedge clk);
        while (!gs.blk_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!gs.blk_ready) begin
            fails++; vectors++;
            $display("FAIL %s_ready_timeout: got ready=0 expected ready=1", who);
        end
    endtask

    task automatic do_start(input logic [127:0] h);
        @(negedge clk);
        gs.start = 1'b1;
        gs.h_key = h;
        @(posedge clk);
        #1 gs.start = 1'b0;
        gs.h_key = $urandom;
        m_h = h; m_y = '0; m_la = '0; m_lc = '0; m_ct = 1'b0; m_err = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] d, input logic t, input int n,
                              input logic with_fin, input logic poke);
        logic legal;
        int   k;
        wait_ready("blk");
        chk("busy_in_msg", {127'b0, gs.busy}, 128'd1);
        gs.blk_valid = 1'b1;
        gs.blk_data  = d;
        gs.blk_type  = t;
        gs.blk_bytes = 5'(n);
        gs.fin       = with_fin;
        legal = (n >= 1) && (n <= 16) && !(t == 1'b0 && m_ct);
        if (legal) begin
            m_y = ref_mul(m_y ^ pad(d, n), m_h);
            if (t) begin m_lc = m_lc + 64'(8 * n); m_ct = 1'b1; end
            else        m_la = m_la + 64'(8 * n);
        end else begin
            m_err = 1'b1;
        end
        @(posedge clk);
        #1 gs.blk_valid = 1'b0;
        gs.fin = 1'b0;
        gs.blk_data = {$urandom, $urandom, $urandom, $urandom};
        k = 0;
        while (k < 300) begin
            @(posedge clk);
            #1 k++;
            if (poke && k == 20) begin
                gs.start = 1'b1; gs.fin = 1'b1; gs.h_key = ~m_h;
            end else if (poke && k == 21) begin
                gs.start = 1'b0; gs.fin = 1'b0;
            end
            if (gs.blk_ready) break;
        end
        chk("ready_gap", 128'(k), legal ? 128'd131 : 128'd1);
    endtask

    task automatic do_fin();
        wait_ready("fin");
        gs.fin = 1'b1;
        exp_q.push_back(ref_mul(m_y ^ {m_la, m_lc}, m_h));
        exp_err_q.push_back(m_err);
        @(posedge clk);
        #1 gs.fin = 1'b0;
    endtask

    task automatic wait_result();
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            fails++; vectors++;
            $display("FAIL s_valid_timeout: got no s_valid expected one within 400 cycles");
            exp_q.delete();
            exp_err_q.delete();
        end
        @(negedge clk);
        chk("busy_after_done", {127'b0, gs.busy}, 128'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && gs.s_valid) begin
            if (exp_q.size() == 0) begin
                fails++; vectors++;
                $display("FAIL unexpected_s_valid: got s_valid=1 s_data=%h expected no result", gs.s_data);
            end else begin
                logic [127:0] e;
                logic [0:0]   ee;
                e  = exp_q.pop_front();
                ee = exp_err_q.pop_front();
                chk("s_data", gs.s_data, e);
                chk("err_at_result", {127'b0, gs.err}, {127'b0, ee});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] d, h, ct_only;
        int nb, n;
        logic t;
        gs.start = 1'b0; gs.h_key = '0; gs.blk_valid = 1'b0; gs.blk_data = '0;
        gs.blk_type = 1'b0; gs.blk_bytes = 5'd0; gs.fin = 1'b0;
        m_h = '0; m_y = '0; m_la = '0; m_lc = '0; m_ct = 1'b0; m_err = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 128'(st), 128'(ST_IDLE));
        chk("rst_ready", {127'b0, gs.blk_ready}, 128'd0);
        chk("rst_busy", {127'b0, gs.busy}, 128'd0);
        chk("rst_s_data", gs.s_data, 128'd0);
        chk("rst_err", {127'b0, gs.err}, 128'd0);
        rst = 1'b0;

        // identity H, one full AAD block
        do_start(H_ID);
        send_block(128'h00112233445566778899aabbccddeeff, 1'b0, 16, 1'b0, 1'b0);
        do_fin();
        wait_result();
        chk("id_aad_const", gs.s_data, 128'h00112233445566f78899aabbccddeeff);

        // identity H, 5-byte CT block
        do_start(H_ID);
        send_block(128'haabbccddeeffffffffffffffffffffff, 1'b1, 5, 1'b0, 1'b0);
        do_fin();
        wait_result();
        chk("id_ct5_const", gs.s_data, 128'haabbccddee0000000000000000000028);

        // H = 0, three blocks; start/fin poked mid-multiply must be ignored
        do_start(128'd0);
        for (int b = 0; b < 3; b++)
            send_block({$urandom, $urandom, $urandom, $urandom}, b[0], $urandom_range(1, 16), 1'b0, b == 1);
        do_fin();
        wait_result();
        chk("h0_const", gs.s_data, 128'd0);

        // empty message
        do_start({$urandom, $urandom, $urandom, $urandom});
        do_fin();
        wait_result();
        chk("empty_s_data", gs.s_data, 128'd0);
        chk("empty_err", {127'b0, gs.err}, 128'd0);

        // CT then AAD: AAD dropped, err raised
        h = {$urandom, $urandom, $urandom, $urandom};
        d = {$urandom, $urandom, $urandom, $urandom};
        n = $urandom_range(1, 16);
        ct_only = ref_mul(ref_mul(pad(d, n), h) ^ {64'd0, 64'(8 * n)}, h);
        do_start(h);
        send_block(d, 1'b1, n, 1'b0, 1'b0);
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 16, 1'b0, 1'b0);
        do_fin();
        wait_result();
        chk("aad_after_ct_err", {127'b0, gs.err}, 128'd1);
        chk("aad_after_ct_s", gs.s_data, ct_only);

        // illegal sizes 0 and 17, plus block offered with fin
        do_start({$urandom, $urandom, $urandom, $urandom});
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 1'b0, 1'b0);
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 7, 1'b1, 1'b0);
        send_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 17, 1'b0, 1'b0);
        do_fin();
        wait_result();

        // reset 50 cycles into MUL
        do_start(H_ID);
        wait_ready("rst_blk");
        gs.blk_valid = 1'b1; gs.blk_data = {$urandom, $urandom, $urandom, $urandom};
        gs.blk_type = 1'b0; gs.blk_bytes = 5'd16;
        @(posedge clk);
        #1 gs.blk_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_state", 128'(st), 128'(ST_IDLE));
        chk("midrst_ready", {127'b0, gs.blk_ready}, 128'd0);
        chk("midrst_busy", {127'b0, gs.busy}, 128'd0);
        chk("midrst_s_valid", {127'b0, gs.s_valid}, 128'd0);
        chk("midrst_s_data", gs.s_data, 128'd0);
        chk("midrst_err", {127'b0, gs.err}, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        do_start(H_ID);
        send_block(128'h00112233445566778899aabbccddeeff, 1'b0, 16, 1'b0, 1'b0);
        do_fin();
        wait_result();
        chk("post_rst_const", gs.s_data, 128'h00112233445566f78899aabbccddeeff);

        // random messages
        for (int m = 0; m < 6; m++) begin
            do_start({$urandom, $urandom, $urandom, $urandom});
            nb = $urandom_range(0, 4);
            for (int b = 0; b < nb; b++) begin
                t = (b >= nb / 2) ^ ($urandom_range(0, 5) == 0);
                n = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 17)
                                                : $urandom_range(1, 16);
                send_block({$urandom, $urandom, $urandom, $urandom}, t, n,
                           $urandom_range(0, 4) == 0, 1'b0);
            end
            do_fin();
            wait_result();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: got no completion expected finish before 2 ms");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
